// File: rtl/rr_arbiter_139.sv
// Four-requester round-robin arbiter driving one half of a 2-to-4 decoder (G/A/B),
// with a hold limit and a mirrored active-low one-hot grant vector.
module rr_arbiter_139 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] REQ,
    output logic       G,
    output logic       A,
    output logic       B,
    output logic [3:0] GNT_L,
    output logic       BUSY
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      last, last_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [HW-1:0]   hcnt, hcnt_nxt;
    logic [1:0]      winner;
    logic            found;
    logic [1:0]      cand;
    logic [3:0]      others;
    logic            g_nxt;
    logic [3:0]      gnt_l_nxt;
    logic            busy_nxt;

    // Rotating-priority pick: LAST+1 first, LAST itself last.
    always_comb begin
        winner = last;
        found  = 1'b0;
        cand   = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && REQ[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        idx_nxt   = idx;
        hcnt_nxt  = hcnt;
        others    = REQ & ~(4'b0001 << idx);

        case (state)
            IDLE, RELEASE: begin
                if (|REQ) begin
                    state_nxt = GRANT;
                    idx_nxt   = winner;
                    last_nxt  = winner;
                    hcnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                hcnt_nxt = (hcnt == HW'(MAX_HOLD)) ? hcnt : hcnt + HW'(1);
                if (!REQ[idx]) begin
                    state_nxt = RELEASE;
                end else if ((hcnt == HW'(MAX_HOLD - 1)) && (|others)) begin
                    state_nxt = RELEASE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next-state view so G/A/B/GNT_L move together.
        g_nxt     = (state_nxt != GRANT);
        busy_nxt  = (state_nxt == GRANT);
        gnt_l_nxt = (state_nxt == GRANT) ? ~(4'b0001 << idx_nxt) : 4'b1111;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            last  <= 2'd3;
            idx   <= 2'd0;
            hcnt  <= '0;
            G     <= 1'b1;
            A     <= 1'b0;
            B     <= 1'b0;
            GNT_L <= 4'b1111;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            idx   <= idx_nxt;
            hcnt  <= hcnt_nxt;
            G     <= g_nxt;
            A     <= idx_nxt[0];
            B     <= idx_nxt[1];
            GNT_L <= gnt_l_nxt;
            BUSY  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_139.sv
// Bench for rr_arbiter_139: two instances (MAX_HOLD=4 and MAX_HOLD=1) checked
// every cycle against a cycle-count reference model and a 2-to-4 decoder function.
module tb_rr_arbiter_139;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic       g0, a0, b0, busy0;
    logic [3:0] gl0;
    logic       g1, a1, b1, busy1;
    logic [3:0] gl1;

    int checks = 0;
    int failures = 0;

    localparam int M_IDLE  = 0;
    localparam int M_GRANT = 1;
    localparam int M_REL   = 2;

    int mh     [2] = '{4, 1};
    int m_mode [2];
    int m_idx  [2];
    int m_last [2];
    int m_held [2];

    always #5 clk = ~clk;

    rr_arbiter_139 #(.MAX_HOLD(4)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .REQ(req),
        .G(g0), .A(a0), .B(b0), .GNT_L(gl0), .BUSY(busy0)
    );

    rr_arbiter_139 #(.MAX_HOLD(1)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .REQ(req),
        .G(g1), .A(a1), .B(b1), .GNT_L(gl1), .BUSY(busy1)
    );

    function automatic logic [3:0] decode(input logic g, input logic b, input logic a);
        logic [3:0] y;
        y = 4'b1111;
        if (!g) y[{b, a}] = 1'b0;
        return y;
    endfunction

    function automatic int pick(input int last, input logic [3:0] r);
        int j;
        for (int k = 1; k <= 4; k++) begin
            j = (last + k) % 4;
            if (r[j]) return j;
        end
        return last;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_mode[n] = M_IDLE;
            m_idx[n]  = 0;
            m_last[n] = 3;
            m_held[n] = 0;
        end
    endtask

    task automatic model_step(input int n, input logic [3:0] r);
        logic [3:0] others;
        if (m_mode[n] == M_GRANT) begin
            others = r & ~(4'b0001 << m_idx[n]);
            if (!r[m_idx[n]])
                m_mode[n] = M_REL;
            else if (m_held[n] == mh[n] && others != 4'b0000)
                m_mode[n] = M_REL;
            else
                m_held[n]++;
        end else if (r != 4'b0000) begin
            m_idx[n]  = pick(m_last[n], r);
            m_last[n] = m_idx[n];
            m_mode[n] = M_GRANT;
            m_held[n] = 1;
        end else begin
            m_mode[n] = M_IDLE;
        end
    endtask

    task automatic check_dut(input int n, input logic g, input logic b, input logic a,
                             input logic [3:0] gl, input logic busy);
        logic       eg;
        logic [3:0] egl;
        logic [1:0] ei;
        eg  = (m_mode[n] != M_GRANT);
        ei  = 2'(m_idx[n]);
        egl = eg ? 4'b1111 : ~(4'b0001 << ei);
        chk($sformatf("dut%0d_G", n), 4'(g), 4'(eg));
        chk($sformatf("dut%0d_BA", n), 4'({b, a}), 4'(ei));
        chk($sformatf("dut%0d_GNT_L", n), gl, egl);
        chk($sformatf("dut%0d_BUSY", n), 4'(busy), 4'(!eg));
        chk($sformatf("dut%0d_decode", n), gl, decode(g, b, a));
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(0, r);
        model_step(1, r);
        @(negedge clk);
        check_dut(0, g0, b0, a0, gl0, busy0);
        check_dut(1, g1, b1, a1, gl1, busy1);
    endtask

    int low_cnt;

    initial begin
        model_reset();
        // Reset held with all requests asserted.
        req = 4'b1111;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_G", 4'(g0), 4'h1);
        chk("rst_GNT_L", gl0, 4'hF);
        chk("rst_BUSY", 4'(busy0), 4'h0);
        chk("rst_BA", 4'({b0, a0}), 4'h0);
        chk("rst_G_b", 4'(g1), 4'h1);
        rst_n = 1'b1;
        step(4'b0000);
        step(4'b0000);

        // Single uncontended requester holds for 20 cycles.
        step(4'b0100);
        chk("single_G", 4'(g0), 4'h0);
        chk("single_BA", 4'({b0, a0}), 4'h2);
        chk("single_GNT_L", gl0, 4'b1011);
        repeat (19) step(4'b0100);
        chk("single_hold_G", 4'(g0), 4'h0);
        step(4'b0000);
        step(4'b0000);

        // Pointer fairness: after 2 held, 0 beats 2.
        step(4'b0101);
        chk("fair_G", 4'(g0), 4'h0);
        chk("fair_BA", 4'({b0, a0}), 4'h0);
        step(4'b0000);
        step(4'b0000);

        // Full rotation with saturating requesters.
        low_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(4'b1111);
            if (!g0) low_cnt++;
        end
        chk("rot_low_cycles", 4'(low_cnt / 2), 4'(10));
        step(4'b0000);
        step(4'b0000);

        // Voluntary release of 1 while 3 waits.
        step(4'b0010);
        step(4'b1010);
        step(4'b1000);
        chk("vol_release_G", 4'(g0), 4'h1);
        step(4'b1000);
        chk("vol_G", 4'(g0), 4'h0);
        chk("vol_BA", 4'({b0, a0}), 4'h3);
        chk("vol_GNT_L", gl0, 4'b0111);
        step(4'b0000);
        step(4'b0000);

        // Asynchronous reset mid-grant takes effect before the next edge.
        step(4'b0001);
        step(4'b0001);
        chk("pre_async_G", 4'(g0), 4'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_G", 4'(g0), 4'h1);
        chk("async_GNT_L", gl0, 4'hF);
        chk("async_BUSY", 4'(busy0), 4'h0);
        chk("async_G_b", 4'(g1), 4'h1);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(4'b0000);

        // Random traffic with sticky requests.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(4'($urandom_range(0, 15)));
            else
                step(req);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
